aclint: RTL and testbench

ACLINT -- requirements
Module: aclint

---
 rtl/aclint.sv | 175 +++++++++++++++++
 tb/tb_aclint.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclint.sv
// ACLINT: machine timer (mtime/mtimecmp) and machine software interrupts (msip) for NumHarts
// harts, accessed through a 64-bit word register port with a one-deep response stage.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_valid_i / req_ready_o     request handshake
//   req_addr_i, req_we_i          byte address (bits [2:0] ignored), write enable
//   req_wmask_i, req_wdata_i      byte enables and write data
//   rsp_valid_o / rsp_ready_i     response handshake (response one cycle after acceptance)
//   rsp_rdata_o, rsp_error_o      read data (0 for writes), unmapped-address flag
//   msip_o, mtip_o                per-hart software / timer interrupts
//   ssip_o                        per-hart supervisor software interrupts (ACLINT_SSWI_EN only)
//
// Configuration: define ACLINT_SSWI_EN to add the ssip registers at 0xC000 and the ssip_o port.
// Without it the 0xC000 region is unmapped.
module aclint #(
   parameter int unsigned NumHarts    = 1,
   parameter int unsigned TickDivider = 40,
   parameter int unsigned AddrWidth   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic                 req_we_i,
   input  logic [7:0]           req_wmask_i,
   input  logic [63:0]          req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [63:0]          rsp_rdata_o,
   output logic                 rsp_error_o,
   output logic [NumHarts-1:0]  msip_o,
`ifdef ACLINT_SSWI_EN
   output logic [NumHarts-1:0]  ssip_o,
`endif
   output logic [NumHarts-1:0]  mtip_o
);

   localparam int unsigned PrescW    = (TickDivider > 1) ? $clog2(TickDivider) : 1;
   localparam int unsigned MsipBase  = 32'h0000;
   localparam int unsigned CmpBase   = 32'h4000;
   localparam int unsigned MtimeAddr = 32'hBFF8;
`ifdef ACLINT_SSWI_EN
   localparam int unsigned SsipBase  = 32'hC000;
`endif

   logic [PrescW-1:0]   presc_q, presc_d;
   logic                tick;
   logic [63:0]         mtime_q, mtime_d;
   logic [63:0]         mtimecmp_q [NumHarts];
   logic [63:0]         mtimecmp_d [NumHarts];
   logic [NumHarts-1:0] msip_q, msip_d;
   logic [NumHarts-1:0] mtip_q, mtip_d;
`ifdef ACLINT_SSWI_EN
   logic [NumHarts-1:0] ssip_q, ssip_d;
`endif

   logic                rsp_valid_q;
   logic [63:0]         rsp_rdata_q;
   logic                rsp_error_q;

   logic                accept;
   logic                wr;
   logic                hit;
   logic [63:0]         rdata;
   logic [AddrWidth-1:0] addr_a;
   logic                unused_addr;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wdata,
                                         input logic [7:0] mask);
      logic [63:0] res;
      for (int unsigned b = 0; b < 8; b++) begin
         res[b*8 +: 8] = mask[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
      end
      return res;
   endfunction

   // Held low during reset so nothing is accepted while state is being cleared.
   assign req_ready_o = ~rst_i & (~rsp_valid_q | rsp_ready_i);
   assign accept      = req_valid_i & req_ready_o;
   assign wr          = accept & req_we_i;
   assign addr_a      = {req_addr_i[AddrWidth-1:3], 3'b000};
   assign unused_addr = ^req_addr_i[2:0];

   always_comb begin
      hit        = 1'b0;
      rdata      = '0;
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
`ifdef ACLINT_SSWI_EN
      ssip_d     = ssip_q;
`endif
      tick    = (presc_q == PrescW'(TickDivider - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      mtime_d = mtime_q + {63'd0, tick};

      // Each 64-bit msip/ssip word carries the even hart at bit 0 and the odd hart at bit 32;
      // the byte enable covering that bit decides whether the bit is written.
      for (int unsigned h = 0; h < NumHarts; h++) begin
         if (addr_a == AddrWidth'(MsipBase + (h / 2) * 8)) begin
            hit = 1'b1;
            rdata[(h % 2) * 32] = msip_q[h];
            if (wr && req_wmask_i[(h % 2) * 4]) msip_d[h] = req_wdata_i[(h % 2) * 32];
         end
`ifdef ACLINT_SSWI_EN
         if (addr_a == AddrWidth'(SsipBase + (h / 2) * 8)) begin
            hit = 1'b1;
            rdata[(h % 2) * 32] = ssip_q[h];
            if (wr && req_wmask_i[(h % 2) * 4]) ssip_d[h] = req_wdata_i[(h % 2) * 32];
         end
`endif
         if (addr_a == AddrWidth'(CmpBase + h * 8)) begin
            hit   = 1'b1;
            rdata = mtimecmp_q[h];
            if (wr) mtimecmp_d[h] = merge(mtimecmp_q[h], req_wdata_i, req_wmask_i);
         end
      end

      // Reads see the pre-increment value; a write overrides (and drops) a same-cycle tick.
      if (addr_a == AddrWidth'(MtimeAddr)) begin
         hit   = 1'b1;
         rdata = mtime_q;
         if (wr) mtime_d = merge(mtime_q, req_wdata_i, req_wmask_i);
      end

      for (int unsigned h = 0; h < NumHarts; h++) begin
         mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q     <= '0;
         mtime_q     <= '0;
         msip_q      <= '0;
         mtip_q      <= '0;
`ifdef ACLINT_SSWI_EN
         ssip_q      <= '0;
`endif
         for (int unsigned h = 0; h < NumHarts; h++) begin
            mtimecmp_q[h] <= '1;
         end
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         msip_q     <= msip_d;
         mtip_q     <= mtip_d;
`ifdef ACLINT_SSWI_EN
         ssip_q     <= ssip_d;
`endif
         mtimecmp_q <= mtimecmp_d;
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_we_i ? 64'd0 : rdata;
            rsp_error_q <= ~hit;
         end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_error_o = rsp_error_q;
   assign msip_o      = msip_q;
   assign mtip_o      = mtip_q;
`ifdef ACLINT_SSWI_EN
   assign ssip_o      = ssip_q;
`endif

endmodule

// File: tb/tb_aclint.sv
// Testbench for aclint (default build: no ssip). Requests are driven with random response
// back-pressure; expected responses are queued at acceptance and popped by a monitor on each
// response handshake. The reference model keeps mtime as (base value, base cycle) and derives
// the current value from the fixed tick schedule, rather than stepping a prescaler.
module tb_aclint;

   localparam int unsigned NH = 3;
   localparam int unsigned TD = 3;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [15:0] req_addr_i = '0;
   logic        req_we_i = 1'b0;
   logic [7:0]  req_wmask_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [63:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic [NH-1:0] msip_o;
   logic [NH-1:0] mtip_o;

   always #5 clk = ~clk;

   aclint #(.NumHarts(NH), .TickDivider(TD), .AddrWidth(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_we_i    (req_we_i),
      .req_wmask_i (req_wmask_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_error_o (rsp_error_o),
      .msip_o      (msip_o),
      .mtip_o      (mtip_o)
   );

   // Cycle index since reset release; cycle c ends at the c-th rising edge.
   int cyc;
   always @(posedge clk or posedge rst_i) begin
      if (rst_i) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } rsp_t;
   rsp_t exp_q[$];
   rsp_t mon_r;

   // Reference model state.
   logic [63:0]   mt_base;
   int            mt_base_cyc;
   logic [63:0]   cmp_m [NH];
   logic [NH-1:0] msip_m;
   logic [NH-1:0] exp_mtip;
   bit            force_rdy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ticks fire at the end of every cycle k with k % TD == TD-1.
   function automatic logic [63:0] mt_at(input int c);
      return mt_base + 64'((c / TD) - (mt_base_cyc / TD));
   endfunction

   function automatic logic [63:0] bmerge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : old[b*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      mt_base     = '0;
      mt_base_cyc = 0;
      for (int h = 0; h < NH; h++) cmp_m[h] = '1;
      msip_m      = '0;
   endtask

   function automatic void model_read(input logic [15:0] addr, input int c,
                                      output logic [63:0] d, output logic e);
      int unsigned a;
      a = {16'd0, addr[15:3], 3'b000};
      d = '0;
      e = 1'b1;
      if (a / 4 < NH) begin
         e    = 1'b0;
         d[0] = msip_m[a / 4];
         if (a / 4 + 1 < NH) d[32] = msip_m[a / 4 + 1];
      end else if (a >= 32'h4000 && (a - 32'h4000) / 8 < NH) begin
         e = 1'b0;
         d = cmp_m[(a - 32'h4000) / 8];
      end else if (a == 32'hBFF8) begin
         e = 1'b0;
         d = mt_at(c);
      end
   endfunction

   task automatic model_write(input logic [15:0] addr, input int c, input logic [7:0] m,
                              input logic [63:0] d);
      int unsigned a;
      a = {16'd0, addr[15:3], 3'b000};
      if (a / 4 < NH) begin
         if (m[0]) msip_m[a / 4] = d[0];
         if (a / 4 + 1 < NH && m[4]) msip_m[a / 4 + 1] = d[32];
      end else if (a >= 32'h4000 && (a - 32'h4000) / 8 < NH) begin
         cmp_m[(a - 32'h4000) / 8] = bmerge(cmp_m[(a - 32'h4000) / 8], d, m);
      end else if (a == 32'hBFF8) begin
         mt_base     = bmerge(mt_at(c), d, m);
         mt_base_cyc = c + 1;
      end
   endtask

   task automatic send(input logic we, input logic [15:0] addr, input logic [7:0] m,
                       input logic [63:0] d);
      int   c;
      bit   ok;
      rsp_t r;
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wmask_i = m;
      req_wdata_i = d;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         rsp_ready_i = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         if (req_ready_o) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: addr %h never accepted", addr);
         req_valid_i = 1'b0;
         return;
      end
      c = cyc;
      model_read(addr, c, r.data, r.err);
      if (we) r.data = '0;
      exp_q.push_back(r);
      @(posedge clk);
      if (we) model_write(addr, c, m, d);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rsp_ready_i = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   endtask

   // Monitor: interrupt outputs every cycle, responses on each handshake.
   always @(negedge clk) begin
      #2;
      if (rst_i) begin
         exp_mtip = '0;
      end else begin
         check("mtip", 64'(mtip_o), 64'(exp_mtip));
         check("msip", 64'(msip_o), 64'(msip_m));
         for (int h = 0; h < NH; h++) exp_mtip[h] = (mt_at(cyc) >= cmp_m[h]);
         if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: got data %h err %b, expected none",
                        rsp_rdata_o, rsp_error_o);
            end else begin
               mon_r = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata_o, mon_r.data);
               check("rsp_error", 64'(rsp_error_o), 64'(mon_r.err));
            end
         end
      end
   end

   logic [15:0] ra;
   logic [63:0] rd;
   logic [63:0] stall_d;

   initial begin
      model_reset();
      #1;
      check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("reset_req_ready", 64'(req_ready_o), 64'd0);
      check("reset_msip", 64'(msip_o), 64'd0);
      check("reset_mtip", 64'(mtip_o), 64'd0);
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1 check("ready_after_reset", 64'(req_ready_o), 64'd1);

      // mtime near reset and after ~100 idle cycles
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);
      idle(100);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);

      // timer compare on hart 0, then disarm
      send(1'b1, 16'h4000, 8'hFF, 64'd10);
      send(1'b1, 16'hBFF8, 8'hFF, 64'd0);
      idle(40);
      send(1'b1, 16'h4000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      idle(3);

      // mtime wrap and partial-mask write
      send(1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);
      idle(8);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);
      send(1'b1, 16'hBFF8, 8'h0F, 64'hAAAA_AAAA_1234_5678);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);

      // msip pair word, third hart, unmapped slot and other unmapped regions
      send(1'b1, 16'h0000, 8'hFF, 64'h0000_0001_0000_0001);
      send(1'b0, 16'h0000, 8'h00, 64'd0);
      send(1'b1, 16'h0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      send(1'b0, 16'h0008, 8'h00, 64'd0);
      send(1'b0, 16'h0010, 8'h00, 64'd0);
      send(1'b1, 16'h4018, 8'hFF, 64'd5);
      send(1'b0, 16'h4018, 8'h00, 64'd0);
      send(1'b0, 16'hC000, 8'h00, 64'd0);
      send(1'b1, 16'h0000, 8'h01, 64'd0);

      // mtime write landing exactly on a tick cycle
      force_rdy = 1'b1;
      idle(2);
      for (int i = 0; i < TD && ((cyc + 1) % TD != TD - 1); i++) idle(1);
      send(1'b1, 16'hBFF8, 8'hFF, 64'd100);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);
      force_rdy = 1'b0;

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0: ra = 16'h0000;
            1: ra = 16'h0008;
            2: ra = 16'h0010;
            3: ra = 16'h4000 + 16'($urandom_range(0, 3) * 8);
            4: ra = 16'hBFF8;
            5: ra = 16'hC000;
            6: ra = 16'($urandom);
            default: ra = 16'h4000 + 16'($urandom_range(0, 2) * 8);
         endcase
         ra = ra | 16'($urandom_range(0, 7));
         rd = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
         send(1'($urandom_range(0, 1)), ra, 8'($urandom), rd);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end

      // response stall, then reset in the middle of it
      force_rdy = 1'b1;
      send(1'b1, 16'h4008, 8'hFF, 64'h0123_4567_89AB_CDEF);
      send(1'b0, 16'h4008, 8'h00, 64'd0);
      stall_d = exp_q[exp_q.size() - 1].data;
      force_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rsp_ready_i = 1'b0;
         #1;
         check("stall_req_ready", 64'(req_ready_o), 64'd0);
         check("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
         check("stall_rdata", rsp_rdata_o, stall_d);
      end
      @(negedge clk);
      rst_i = 1'b1;
      #1;
      check("midreset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("midreset_rdata", rsp_rdata_o, 64'd0);
      check("midreset_error", 64'(rsp_error_o), 64'd0);
      check("midreset_req_ready", 64'(req_ready_o), 64'd0);
      check("midreset_msip", 64'(msip_o), 64'd0);
      check("midreset_mtip", 64'(mtip_o), 64'd0);
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      #1 check("ready_after_reset2", 64'(req_ready_o), 64'd1);
      force_rdy = 1'b1;
      idle(5);
      send(1'b0, 16'h4000, 8'h00, 64'd0);
      send(1'b0, 16'h4008, 8'h00, 64'd0);
      send(1'b0, 16'h4010, 8'h00, 64'd0);
      send(1'b0, 16'hBFF8, 8'h00, 64'd0);

      // drain
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
      idle(2);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
